// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one request/ack bus transaction per load or store,
// with byte-lane steering, load formatting, misalignment detection and a bus watchdog.
//
// state  | meaning
// IDLE   | no transaction; accept an aligned, legal access
// WAIT   | request outstanding; wait for ack or watchdog expiry
// DONE   | transaction complete; pipeline advances this cycle
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic        mem_mem_read_i,
    input  logic        mem_mem_write_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_alu_result_i,
    input  logic [31:0] mem_rs2_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        access, is_store, legal, aligned, start, wd_expire;
    logic [1:0]  off;
    logic [3:0]  be_st;
    logic [31:0] wdata_st;
    logic [7:0]  wd_cnt;
    logic [1:0]  ld_off;
    logic [2:0]  ld_funct3;
    logic        ld_is_load;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    assign off      = mem_alu_result_i[1:0];
    assign is_store = mem_mem_write_i;
    assign access   = mem_valid_i & (mem_mem_read_i | mem_mem_write_i);

    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        case (mem_funct3_i)
            3'b000: begin legal = 1'b1;      aligned = 1'b1;       end
            3'b001: begin legal = 1'b1;      aligned = ~off[0];    end
            3'b010: begin legal = 1'b1;      aligned = (off == 2'b00); end
            3'b100: begin legal = ~is_store; aligned = 1'b1;       end
            3'b101: begin legal = ~is_store; aligned = ~off[0];    end
            default: begin legal = 1'b0;     aligned = 1'b0;       end
        endcase
    end

    assign start      = (state == S_IDLE) & access & legal & aligned;
    assign stall_o    = start | (state == S_WAIT);
    assign misalign_o = (state == S_IDLE) & access & ~(legal & aligned);
    assign wd_expire  = (wd_cnt == WD_LAST);

    always_comb begin
        be_st    = 4'b1111;
        wdata_st = mem_rs2_data_i;
        case (mem_funct3_i[1:0])
            2'b00: begin
                be_st    = 4'b0001 << off;
                wdata_st = {4{mem_rs2_data_i[7:0]}};
            end
            2'b01: begin
                be_st    = 4'b0011 << off;
                wdata_st = {2{mem_rs2_data_i[15:0]}};
            end
            default: begin
                be_st    = 4'b1111;
                wdata_st = mem_rs2_data_i;
            end
        endcase
    end

    // Load formatting uses the offset/size captured at request time, not the live inputs.
    assign rd_shift = dmem_rdata_i >> {ld_off, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = ld_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        rd_fmt = dmem_rdata_i;
        case (ld_funct3)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_fmt = {24'h000000, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_fmt = {16'h0000, rd_half};
            default: rd_fmt = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT:  if (dmem_ack_i || wd_expire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0;
            dmem_be_o    <= 4'h0;
            dmem_wdata_o <= 32'h0;
            mem_rdata_o  <= 32'h0;
            bus_err_o    <= 1'b0;
            wd_cnt       <= 8'h0;
            ld_off       <= 2'b00;
            ld_funct3    <= 3'b000;
            ld_is_load   <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_store;
                        dmem_addr_o  <= {mem_alu_result_i[31:2], 2'b00};
                        dmem_be_o    <= is_store ? be_st : 4'b1111;
                        dmem_wdata_o <= is_store ? wdata_st : 32'h0;
                        ld_off       <= off;
                        ld_funct3    <= mem_funct3_i;
                        ld_is_load   <= ~is_store;
                        wd_cnt       <= 8'h0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        if (ld_is_load) mem_rdata_o <= rd_fmt;
                    end else if (wd_expire) begin
                        dmem_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        if (ld_is_load) mem_rdata_o <= 32'h0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32IM pipeline. It consumes the address, store data and memory controls held in the EX/MEM register and runs a request/acknowledge transaction on the data-memory bus. It stalls the pipeline until that transaction completes, then drives the aligned, sign/zero-extended load data into the MEM/WB register's `mem_rdata_i`. It also handles byte-lane steering, misalignment detection and a bus watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles without `dmem_ack_i` before the transaction is abandoned. Legal range is 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_valid_i` input 1: a valid instruction is present in the MEM stage.
- `mem_mem_read_i` input 1: load.
- `mem_mem_write_i` input 1: store; wins if both read and write are set.
- `mem_funct3_i` input 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_alu_result_i` input 32: effective byte address.
- `mem_rs2_data_i` input 32: store data.
- `dmem_req_o` output 1: bus request; registered.
- `dmem_we_o` output 1: write enable; registered.
- `dmem_addr_o` output 32: word address `{addr[31:2],2'b00}`; registered.
- `dmem_be_o` output 4: byte enables; registered.
- `dmem_wdata_o` output 32: lane-replicated store data; registered.
- `dmem_rdata_i` input 32: read data; valid when `dmem_ack_i`=1.
- `dmem_ack_i` input 1: completes the current request.
- `mem_rdata_o` output 32: formatted load data to MEM/WB; registered.
- `stall_o` output 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `misalign_o` output 1: misaligned access or illegal funct3; combinational.
- `bus_err_o` output 1: one-cycle pulse on watchdog expiry.

## Operation
- FSM has three states: IDLE, WAIT, DONE. Reset state is IDLE.
- **Access** = `mem_valid_i & (read | write)`.
- **Aligned**:
  - B/BU: always.
  - H/HU: `addr[0]`=0.
  - W: `addr[1:0]`=0.
  - funct3 011/110/111 are illegal; store treats 1xx as illegal too.
- **IDLE**:
  - On an access that is aligned and legal: latch the bus fields, set `dmem_req_o`=1, go to WAIT. `stall_o`=1 (combinational) in this cycle.
  - On an access that is misaligned or illegal: `misalign_o`=1, no request, `stall_o`=0, `mem_rdata_o` unchanged.
  - Otherwise: `stall_o`=0.
- **WAIT**:
  - `stall_o`=1. Bus outputs are held stable while `dmem_req_o`=1. The watchdog counter increments each cycle.
  - On `dmem_ack_i`=1: drop `dmem_req_o`. For a load, register the formatted data into `mem_rdata_o`. Go to DONE.
  - When the counter reaches `TIMEOUT_CYCLES` with no ack: drop `dmem_req_o`. For a load, set `mem_rdata_o`=0. Go to DONE with `bus_err_o`=1.
- **DONE**:
  - `stall_o`=0, so the pipeline advances at the end of this cycle and MEM/WB captures `mem_rdata_o`.
  - `bus_err_o` is high only in DONE following a timeout.
  - Next state is always IDLE. An access presented in DONE is the completed instruction and is ignored.
- **Store lanes** (`off`=`addr[1:0]`):
  - B: `be`=0001<<`off`, `wdata`={4{rs2[7:0]}}.
  - H: `be`=0011<<`off`, `wdata`={2{rs2[15:0]}}.
  - W: `be`=1111, `wdata`=rs2.
  - Loads: `be`=1111, `we`=0.
- **Load format**, using the latched `off` and funct3:
  - B/BU: byte at lane `off`, sign- or zero-extended.
  - H/HU: half at `off[1]`, sign- or zero-extended.
  - W: the full word.
- Reset values: `dmem_req_o`/`we`=0, `addr`/`be`/`wdata`=0, `mem_rdata_o`=0, `bus_err_o`=0, counter=0. `stall_o`/`misalign_o` are driven by inputs only.
- Asserting reset in any state returns immediately to IDLE and aborts any outstanding request.
- `dmem_ack_i` outside WAIT is ignored, including a late ack arriving after a timeout.
- A store does not modify `mem_rdata_o`.

## Timing
- Minimum memory op is 3 cycles: IDLE, then WAIT with ack in the first WAIT cycle, then DONE. This costs 2 stall cycles.
- Each cycle of ack delay adds one stall cycle.
- Timeout path: the instruction spends `TIMEOUT_CYCLES` cycles in WAIT, then one cycle in DONE.
- Non-memory and misaligned instructions pass in 1 cycle with no stall.
- `mem_rdata_o` is valid from the DONE cycle and holds until the next load ack.

## Test plan
- **LW, immediate ack.** LW at addr 0x100, `dmem_rdata_i`=0xDEADBEEF with ack in the first WAIT cycle. Expect `stall_o` 1,1,0, `dmem_addr_o`=0x100, `be`=1111, `mem_rdata_o`=0xDEADBEEF in DONE.
- **LB / LBU / LHU.** LB at 0x103 with rdata 0x80FF_0000 gives 0xFFFFFF80. LBU at the same address gives 0x00000080. LHU at 0x102 gives 0x000080FF.
- **SB and SH lanes.** SB at 0x201 with rs2=0x12345678 gives `be`=0010, `wdata`=0x78787878, `we`=1, and `mem_rdata_o` unchanged. SH at 0x202 gives `be`=1100, `wdata`=0x56785678.
- **Misaligned and illegal accesses.** LW at 0x102, SH at 0x101, and funct3=011: each gives `misalign_o`=1, no `dmem_req_o`, `stall_o`=0.
- **Watchdog.** With `TIMEOUT_CYCLES`=4 and no ack: 4 WAIT cycles, then DONE with `bus_err_o`=1 for one cycle and `mem_rdata_o`=0. A late ack 2 cycles later causes no state change.
- **Reset mid-transaction.** Deassert `rst_n` in the 2nd WAIT cycle. Outputs go to reset values immediately and the FSM is in IDLE. The next LW completes normally.
